alu_muldiv: RTL and testbench

//  Multi-cycle integer multiply/divide unit beside the single-cycle ALU in the execute stage.

---
 rtl/alu_muldiv_pkg.sv | 38 +++
 rtl/alu_muldiv_if.sv | 32 +++
 rtl/alu_muldiv_step.sv | 46 ++++
 rtl/alu_muldiv.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_muldiv_pkg.sv
// ============================================================================
//  Module : alu_muldiv_pkg
//  Brief  : Opcodes, FSM state type and opcode helpers for the mul/div unit.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_muldiv_pkg;

    localparam logic [2:0] c_MD_MULT  = 3'd0;
    localparam logic [2:0] c_MD_MULTU = 3'd1;
    localparam logic [2:0] c_MD_DIV   = 3'd2;
    localparam logic [2:0] c_MD_DIVU  = 3'd3;
    localparam logic [2:0] c_MD_MTHI  = 3'd4;
    localparam logic [2:0] c_MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == c_MD_MULT) || (op == c_MD_MULTU) ||
               (op == c_MD_DIV)  || (op == c_MD_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == c_MD_MULT) || (op == c_MD_DIV);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == c_MD_DIV) || (op == c_MD_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_muldiv_if.sv
// ============================================================================
//  Module : alu_muldiv_if
//  Brief  : Control-unit to mul/div unit request/result interface.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

interface alu_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             flush;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, flush, op, operand1, operand2,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, flush, op, operand1, operand2,
        output busy, done, hi, lo
    );
endinterface

`default_nettype wire

// File: rtl/alu_muldiv_step.sv
// ============================================================================
//  Module : muldiv_step
//  Brief  : One combinational iteration: shift-add multiply or restoring divide.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  wire logic             is_div,
    input  wire logic [WIDTH-1:0] acc_in,
    input  wire logic [WIDTH-1:0] q_in,
    input  wire logic [WIDTH-1:0] operand,
    output logic      [WIDTH-1:0] acc_out,
    output logic      [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, acc_in} + (q_in[0] ? {1'b0, operand} : '0);
        w_shift = {acc_in, q_in[WIDTH-1]};
        // Only used when w_shift >= operand, so the result always fits WIDTH bits
        w_diff  = w_shift[WIDTH-1:0] - operand;
        acc_out = '0;
        q_out   = '0;
        if (is_div) begin
            if (w_shift >= {1'b0, operand}) begin
                acc_out = w_diff;
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = w_shift[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = w_sum[WIDTH:1];
            q_out   = {w_sum[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
//  Module : alu_muldiv
//  Brief  : Iterative MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  wire logic  clk,
    input  wire logic  rstn,
    alu_muldiv_if.slave bus
);

    localparam int c_N  = WIDTH / STEP;
    localparam int c_CW = $clog2(c_N + 1);

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_mag_b;
    logic [WIDTH-1:0]  r_a;
    logic              r_is_div;
    logic              r_div0;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;

    logic              w_sgn;
    logic [WIDTH-1:0]  w_a_mag;
    logic [WIDTH-1:0]  w_b_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]  w_quot;
    logic [WIDTH-1:0]  w_rem;

    // Datapath works on magnitudes; signs are reapplied in FIX
    assign w_sgn   = is_signed_op(bus.op);
    assign w_a_mag = (w_sgn && bus.operand1[WIDTH-1]) ? -bus.operand1 : bus.operand1;
    assign w_b_mag = (w_sgn && bus.operand2[WIDTH-1]) ? -bus.operand2 : bus.operand2;
    assign w_prod  = r_neg_q ? -{r_acc, r_q} : {r_acc, r_q};
    assign w_quot  = r_neg_q ? -r_q   : r_q;
    assign w_rem   = r_neg_r ? -r_acc : r_acc;

    generate
        for (genvar gi = 0; gi < STEP; gi++) begin : g_step
            logic [WIDTH-1:0] w_acc_in;
            logic [WIDTH-1:0] w_q_in;
            logic [WIDTH-1:0] w_acc_out;
            logic [WIDTH-1:0] w_q_out;
            if (gi == 0) begin : g_first
                assign w_acc_in = r_acc;
                assign w_q_in   = r_q;
            end else begin : g_next
                assign w_acc_in = g_step[gi-1].w_acc_out;
                assign w_q_in   = g_step[gi-1].w_q_out;
            end
            muldiv_step #(.WIDTH(WIDTH)) u_step (
                .is_div  (r_is_div),
                .acc_in  (w_acc_in),
                .q_in    (w_q_in),
                .operand (r_mag_b),
                .acc_out (w_acc_out),
                .q_out   (w_q_out)
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_q      <= '0;
            r_mag_b  <= '0;
            r_a      <= '0;
            r_is_div <= 1'b0;
            r_div0   <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (bus.flush) begin
                r_state <= S_IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            if (is_arith_op(bus.op)) begin
                                r_is_div <= is_div_op(bus.op);
                                r_acc    <= '0;
                                r_q      <= w_a_mag;
                                r_mag_b  <= w_b_mag;
                                r_a      <= bus.operand1;
                                r_div0   <= (bus.operand2 == '0);
                                r_neg_q  <= w_sgn & (bus.operand1[WIDTH-1] ^ bus.operand2[WIDTH-1]);
                                r_neg_r  <= w_sgn & bus.operand1[WIDTH-1];
                                r_cnt    <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= S_CALC;
                            end else if (bus.op == c_MD_MTHI) begin
                                r_hi   <= bus.operand1;
                                r_done <= 1'b1;
                            end else if (bus.op == c_MD_MTLO) begin
                                r_lo   <= bus.operand1;
                                r_done <= 1'b1;
                            end
                        end
                    end
                    S_CALC: begin
                        r_acc <= g_step[STEP-1].w_acc_out;
                        r_q   <= g_step[STEP-1].w_q_out;
                        r_cnt <= r_cnt + c_CW'(1);
                        if (r_cnt == c_CW'(c_N - 1)) begin
                            r_state <= S_FIX;
                        end
                    end
                    S_FIX: begin
                        // MIN / -1 falls out of the magnitude path as lo=MIN, hi=0
                        if (r_is_div) begin
                            if (r_div0) begin
                                r_lo <= '1;
                                r_hi <= r_a;
                            end else begin
                                r_lo <= w_quot;
                                r_hi <= w_rem;
                            end
                        end else begin
                            {r_hi, r_lo} <= w_prod;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_muldiv.sv
// ============================================================================
//  Module : tb_alu_muldiv
//  Brief  : Directed vector table plus handshake/flush/reset sequences.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_alu_muldiv;
    import alu_muldiv_pkg::*;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    alu_muldiv_if #(.WIDTH(32)) bus ();

    alu_muldiv #(.WIDTH(32), .STEP(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the accept edge; returns aligned just after the done cycle's edge
    task automatic wait_done(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        int          busy_cnt;
        int          done_at;
        logic        done_busy;
        logic [31:0] ghi;
        logic [31:0] glo;
        busy_cnt  = 0;
        done_at   = 0;
        done_busy = 1'b1;
        ghi       = '0;
        glo       = '0;
        for (int c = 1; c <= 60 && done_at == 0; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_at   = c;
                done_busy = bus.busy;
                ghi       = bus.hi;
                glo       = bus.lo;
            end
        end
        check({name, ".done_cycle"}, 64'(done_at), 64'd34);
        check({name, ".busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({name, ".busy_at_done"}, 64'(done_busy), 64'd0);
        check({name, ".hi"}, 64'(ghi), 64'(ehi));
        check({name, ".lo"}, 64'(glo), 64'(elo));
        tick();
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start    = 1'b1;
        bus.op       = op;
        bus.operand1 = a;
        bus.operand2 = b;
        tick();
        bus.start    = 1'b0;
        bus.op       = 3'd7;
        bus.operand1 = $urandom;
        bus.operand2 = $urandom;
    endtask

    initial begin
        int seen;
        n_vec = 0;
        n_err = 0;

        vecs[0]  = '{"mult_m3x5",      c_MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[1]  = '{"multu_max",      c_MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{"divu_100_7",     c_MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3]  = '{"div_m7_2",       c_MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{"div_by_zero",    c_MD_DIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF};
        vecs[5]  = '{"div_min_m1",     c_MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{"mult_7xm6",      c_MD_MULT,  32'd7,        32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6};
        vecs[7]  = '{"divu_max_16",    c_MD_DIVU,  32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF};
        vecs[8]  = '{"div_7_m2",       c_MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{"multu_2p31x2",   c_MD_MULTU, 32'h80000000, 32'd2,        32'h00000001, 32'h00000000};
        vecs[10] = '{"divu_by_zero",   c_MD_DIVU,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF};
        vecs[11] = '{"div_m8_m3",      c_MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[12] = '{"mult_min_min",   c_MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        rstn         = 1'b0;
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        bus.op       = 3'd0;
        bus.operand1 = '0;
        bus.operand2 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi", 64'(bus.hi), 64'd0);
        check("reset.lo", 64'(bus.lo), 64'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        tick();

        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(vecs[i].name, vecs[i].hi, vecs[i].lo);
        end

        // MTHI, then MULT issued in the MTHI done cycle
        bus.start    = 1'b1;
        bus.op       = c_MD_MTHI;
        bus.operand1 = 32'h0000BEEF;
        tick();
        bus.op       = c_MD_MULT;
        bus.operand1 = 32'd2;
        bus.operand2 = 32'd3;
        @(negedge clk);
        check("mthi.done", 64'(bus.done), 64'd1);
        check("mthi.busy", 64'(bus.busy), 64'd0);
        check("mthi.hi", 64'(bus.hi), 64'h0000BEEF);
        tick();
        bus.start    = 1'b0;
        bus.operand1 = $urandom;
        wait_done("b2b_mult", 32'h0, 32'h6);

        // MTLO single-cycle pulse
        issue(c_MD_MTLO, 32'h12345678, 32'h0);
        @(negedge clk);
        check("mtlo.done", 64'(bus.done), 64'd1);
        check("mtlo.lo", 64'(bus.lo), 64'h12345678);
        tick();
        @(negedge clk);
        check("mtlo.done_drop", 64'(bus.done), 64'd0);
        tick();
        issue(c_MD_MTLO, 32'h6, 32'h0);
        tick();

        // DIVU 9/3: ignored start at k+5, flush at k+10
        issue(c_MD_DIVU, 32'd9, 32'd3);
        repeat (4) tick();
        bus.start    = 1'b1;
        bus.op       = c_MD_MTHI;
        bus.operand1 = 32'h0000DEAD;
        tick();
        bus.start    = 1'b0;
        repeat (4) tick();
        bus.flush    = 1'b1;
        @(negedge clk);
        check("flush.busy_before", 64'(bus.busy), 64'd1);
        tick();
        bus.flush    = 1'b0;
        @(negedge clk);
        check("flush.busy_after", 64'(bus.busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        check("flush.no_done", 64'(seen), 64'd0);
        check("flush.hi_kept", 64'(bus.hi), 64'h0);
        check("flush.lo_kept", 64'(bus.lo), 64'h6);
        tick();

        // flush beats start
        bus.start    = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = c_MD_MTLO;
        bus.operand1 = 32'h0000AAAA;
        tick();
        bus.start    = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        check("flush_start.done", 64'(bus.done), 64'd0);
        check("flush_start.lo", 64'(bus.lo), 64'h6);
        tick();

        // invalid opcode is a no-op
        issue(3'd6, 32'h11111111, 32'h22222222);
        @(negedge clk);
        check("invalid.busy", 64'(bus.busy), 64'd0);
        check("invalid.done", 64'(bus.done), 64'd0);
        check("invalid.hi", 64'(bus.hi), 64'h0);
        tick();

        // asynchronous reset in the middle of a MULT
        issue(c_MD_MULT, 32'd7, 32'd9);
        repeat (10) tick();
        @(negedge clk);
        check("midrst.busy_before", 64'(bus.busy), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check("midrst.busy", 64'(bus.busy), 64'd0);
        check("midrst.done", 64'(bus.done), 64'd0);
        check("midrst.hi", 64'(bus.hi), 64'd0);
        check("midrst.lo", 64'(bus.lo), 64'd0);
        tick();
        rstn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
